boundary_gen: RTL

Procedural river-bank generator feeding the boundary memory. Each scroll step it computes one new 40-bit scanline boundary word (left bank, island left, island right, right bank), presents it on `row_data`, and toggles `shift` so the memory advances its ring pointers and writes the word. After reset it first back-fills a whole screen of rows without waiting for scroll ticks, then produces one row per `scroll_tick`.

---
 rtl/boundary_gen_if.sv | 25 ++
 rtl/boundary_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/boundary_gen_if.sv
// Scroll-request / row-output bundle between the river-bank generator and
// the boundary memory. The generator drives everything except scroll_tick.
interface boundary_gen_if;
  logic        scroll_tick;
  logic [39:0] row_data;
  logic        shift;
  logic        busy;
  logic        ready;

  modport master (
    output scroll_tick,
    input  row_data,
    input  shift,
    input  busy,
    input  ready
  );

  modport slave (
    input  scroll_tick,
    output row_data,
    output shift,
    output busy,
    output ready
  );
endinterface

// File: rtl/boundary_gen.sv
// Procedural river-bank generator: random-walks river center and half-width toward
// LFSR-picked segment targets and emits one 40-bit scanline boundary word per row.
module boundary_gen #(
  parameter int unsigned ROWS       = 480,
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned MARGIN     = 8,
  parameter int unsigned MIN_HW     = 40,
  parameter int unsigned MAX_HW     = 280,
  parameter int unsigned ISL_MIN_HW = 120,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input logic          clk,
  input logic          reset,
  boundary_gen_if.slave bus
);

  localparam logic [9:0]  MARGIN_C  = 10'(MARGIN);
  localparam logic [9:0]  X_MAX_C   = 10'(SCREEN_W - 1 - MARGIN);
  localparam logic [9:0]  MIN_HW_C  = 10'(MIN_HW);
  localparam logic [9:0]  MAX_HW_C  = 10'(MAX_HW);
  localparam logic [9:0]  ISL_HW_C  = 10'(ISL_MIN_HW);
  localparam logic [9:0]  C_BASE_C  = 10'd192;
  localparam logic [8:0]  ROWS_C    = 9'(ROWS);
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    S_PRELOAD = 3'd0,
    S_IDLE    = 3'd1,
    S_PICK    = 3'd2,
    S_STEP    = 3'd3,
    S_EMIT    = 3'd4,
    S_GUARD   = 3'd5
  } state_e;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    lfsr_adv = {1'b0, l[15:1]} ^ (l[0] ? LFSR_MASK : 16'h0000);
  endfunction

  function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] lo,
                                         input logic [9:0] hi);
    if (v < lo) clamp10 = lo;
    else if (v > hi) clamp10 = hi;
    else clamp10 = v;
  endfunction

  function automatic logic [9:0] toward(input logic [9:0] cur, input logic [9:0] tgt);
    if (cur < tgt) toward = cur + 10'd1;
    else if (cur > tgt) toward = cur - 10'd1;
    else toward = cur;
  endfunction

  function automatic logic [39:0] make_row(input logic [9:0] c, input logic [9:0] hw,
                                           input logic isl);
    logic [9:0] q;
    q = (isl && (hw >= ISL_HW_C)) ? {2'b00, hw[9:2]} : 10'd0;
    make_row = {c - hw, c - q, c + q, c + hw};
  endfunction

  state_e      state_q;
  logic [9:0]  center_q, hw_q, c_tgt_q, hw_tgt_q;
  logic [6:0]  seg_cnt_q;
  logic        isl_en_q;
  logic [15:0] lfsr_q;
  logic [8:0]  pre_cnt_q;
  logic        pending_q;
  logic [1:0]  guard_q;
  logic [39:0] row_data_q;
  logic        shift_q, busy_q, ready_q;

  logic [15:0] lfsr_d;
  logic [9:0]  rnd_s, hw_tgt_d, c_tgt_d, hw_d, center_d;
  logic [6:0]  seg_d;
  logic        isl_en_d;
  logic        pending_d;
  state_e      disp_state_d;
  logic        disp_busy_d, disp_ready_d;

  // Segment-target pick and per-row step arithmetic
  always_comb begin
    lfsr_d = lfsr_adv(lfsr_q);
    rnd_s  = {2'b00, lfsr_d[15:8]};
    if ((MIN_HW_C + rnd_s) > MAX_HW_C) hw_tgt_d = MAX_HW_C;
    else hw_tgt_d = MIN_HW_C + rnd_s;
    // bounds derive from the target half-width first, so the subtraction never wraps
    c_tgt_d  = clamp10(C_BASE_C + rnd_s, hw_tgt_d + MARGIN_C, X_MAX_C - hw_tgt_d);
    seg_d    = 7'd16 + {1'b0, lfsr_d[5:0]};
    isl_en_d = lfsr_d[0] & (hw_tgt_d >= ISL_HW_C);
    hw_d     = toward(hw_q, hw_tgt_q);
    center_d = clamp10(toward(center_q, c_tgt_q), hw_d + MARGIN_C, X_MAX_C - hw_d);
  end

  // Next-row dispatch shared by PRELOAD, IDLE and the last GUARD cycle
  always_comb begin
    disp_state_d = S_IDLE;
    disp_busy_d  = 1'b0;
    disp_ready_d = ready_q;
    pending_d    = pending_q | (ready_q & bus.scroll_tick);
    if (!ready_q) begin
      if (pre_cnt_q == ROWS_C) begin
        disp_state_d = S_IDLE;
        disp_busy_d  = 1'b0;
        disp_ready_d = 1'b1;
      end else begin
        disp_state_d = (seg_cnt_q == 7'd0) ? S_PICK : S_STEP;
        disp_busy_d  = 1'b1;
      end
    end else if (pending_q || bus.scroll_tick) begin
      disp_state_d = (seg_cnt_q == 7'd0) ? S_PICK : S_STEP;
      disp_busy_d  = 1'b1;
    end else begin
      disp_state_d = S_IDLE;
      disp_busy_d  = 1'b0;
    end
  end

  // Generator FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_PRELOAD;
      center_q   <= 10'd320;
      hw_q       <= 10'd160;
      c_tgt_q    <= 10'd320;
      hw_tgt_q   <= 10'd160;
      seg_cnt_q  <= 7'd0;
      isl_en_q   <= 1'b0;
      lfsr_q     <= SEED;
      pre_cnt_q  <= 9'd0;
      pending_q  <= 1'b0;
      guard_q    <= 2'd0;
      row_data_q <= {10'd160, 10'd320, 10'd320, 10'd480};
      shift_q    <= 1'b0;
      busy_q     <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        S_PRELOAD, S_IDLE: begin
          state_q   <= disp_state_d;
          busy_q    <= disp_busy_d;
          ready_q   <= disp_ready_d;
          pending_q <= 1'b0;
        end
        S_PICK: begin
          lfsr_q    <= lfsr_d;
          seg_cnt_q <= seg_d;
          hw_tgt_q  <= hw_tgt_d;
          c_tgt_q   <= c_tgt_d;
          isl_en_q  <= isl_en_d;
          pending_q <= pending_d;
          state_q   <= S_STEP;
        end
        S_STEP: begin
          hw_q      <= hw_d;
          center_q  <= center_d;
          seg_cnt_q <= seg_cnt_q - 7'd1;
          pending_q <= pending_d;
          state_q   <= S_EMIT;
        end
        S_EMIT: begin
          row_data_q <= make_row(center_q, hw_q, isl_en_q);
          shift_q    <= ~shift_q;
          if (!ready_q) pre_cnt_q <= pre_cnt_q + 9'd1;
          guard_q    <= 2'd0;
          pending_q  <= pending_d;
          state_q    <= S_GUARD;
        end
        S_GUARD: begin
          // the third guard cycle dispatches directly, keeping the row period at 5
          if (guard_q == 2'd2) begin
            state_q   <= disp_state_d;
            busy_q    <= disp_busy_d;
            ready_q   <= disp_ready_d;
            pending_q <= 1'b0;
          end else begin
            guard_q   <= guard_q + 2'd1;
            pending_q <= pending_d;
          end
        end
        default: begin
          state_q <= S_PRELOAD;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.row_data = row_data_q;
  assign bus.shift    = shift_q;
  assign bus.busy     = busy_q;
  assign bus.ready    = ready_q;

endmodule
